spi_fwm_rxf_ctrl: RTL and testbench

//  Firmware-mode RX buffer writer, directly downstream of the SPI RX byte path (after its CDC FIFO).

---
 rtl/spi_fwm_rxf_ctrl.sv | 159 +++++++++++++++
 tb/tb_spi_fwm_rxf_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fwm_rxf_ctrl.sv
// Firmware-mode RX buffer writer: packs popped RX bytes into 32-bit words and
// writes them into a circular DPSRAM region, exposing a byte-granular write pointer.
module spi_fwm_rxf_ctrl #(
  parameter int SramAw = 9,
  parameter int PtrW   = SramAw + 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fifo_rvalid_i,
  output logic              fifo_rready_o,
  input  logic [7:0]        fifo_rdata_i,
  input  logic [SramAw-1:0] base_i,
  input  logic [SramAw-1:0] limit_i,
  input  logic [7:0]        timer_i,
  input  logic [PtrW-1:0]   rptr_i,
  output logic [PtrW-1:0]   wptr_o,
  output logic              full_o,
  output logic [PtrW-1:0]   depth_o,
  output logic              sram_req_o,
  input  logic              sram_gnt_i,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [3:0]        sram_wmask_o
);

  localparam int OffW  = SramAw + 2;
  localparam int FillW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StWrite,
    StUpdate
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      timer_q, timer_d;
  logic [31:0]     wdata_p0, wdata_d;
  logic [3:0]      wmask_p0, wmask_d;

  logic [SramAw-1:0] span;
  logic [PtrW-1:0]   capacity;
  logic [OffW-1:0]   w_off, r_off;
  logic              phase_diff;
  logic [PtrW-1:0]   depth;
  logic [FillW-1:0]  fill;
  logic              pop;
  logic [1:0]        lane;

  // Advance the pointer by the bytes just written; the word count wraps to
  // offset 0 (toggling phase) only when the last region word is completed.
  function automatic logic [PtrW-1:0] ptr_advance(input logic [PtrW-1:0]   ptr,
                                                   input logic [2:0]        nbytes,
                                                   input logic [SramAw-1:0] last_word);
    logic [2:0] bsum;
    bsum = {1'b0, ptr[1:0]} + nbytes;
    if ((ptr[PtrW-2:2] == last_word) && (bsum == 3'd4)) begin
      return {~ptr[PtrW-1], {OffW{1'b0}}};
    end
    return {ptr[PtrW-1], ptr[OffW-1:0] + OffW'(nbytes)};
  endfunction

  assign span       = limit_i - base_i;
  assign capacity   = {1'b0, span, 2'b00} + PtrW'(4);
  assign w_off      = wptr_q[OffW-1:0];
  assign r_off      = rptr_i[OffW-1:0];
  assign phase_diff = wptr_q[PtrW-1] ^ rptr_i[PtrW-1];
  assign depth      = phase_diff ? (capacity - {1'b0, r_off - w_off})
                                 : {1'b0, w_off - r_off};
  assign fill       = {1'b0, depth} + FillW'(cnt_q);
  assign lane       = wptr_q[1:0] + cnt_q[1:0];
  assign pop        = fifo_rvalid_i
                    & ((state_q == StIdle) | (state_q == StPack))
                    & (fill < {1'b0, capacity});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    wptr_d  = wptr_q;
    wdata_d = wdata_p0;
    wmask_d = wmask_p0;

    if (pop) begin
      wdata_d[{lane, 3'b000} +: 8] = fifo_rdata_i;
      wmask_d[lane]                = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          cnt_d   = 3'd1;
          timer_d = 8'd0;
          state_d = (lane == 2'd3) ? StWrite : StPack;
        end
      end
      StPack: begin
        // A pop on the expiry cycle takes priority and restarts the idle timer.
        if (pop) begin
          cnt_d   = cnt_q + 3'd1;
          timer_d = 8'd0;
          if (lane == 2'd3) state_d = StWrite;
        end else begin
          timer_d = timer_q + 8'd1;
          if ((timer_i != 8'd0) && (timer_q == timer_i - 8'd1)) state_d = StWrite;
        end
      end
      StWrite: begin
        // Pointer commits on the grant edge so it is visible during StUpdate.
        if (sram_gnt_i) begin
          wptr_d  = ptr_advance(wptr_q, cnt_q, span);
          cnt_d   = 3'd0;
          timer_d = 8'd0;
          wmask_d = 4'h0;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      cnt_q    <= 3'd0;
      timer_q  <= 8'd0;
      wmask_p0 <= 4'h0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      wmask_p0 <= wmask_d;
    end
  end

  always_ff @(posedge clk_i) begin
    wdata_p0 <= wdata_d;
  end

  // Bus outputs are only driven while a write is outstanding.
  assign sram_req_o    = (state_q == StWrite);
  assign sram_addr_o   = sram_req_o ? (base_i + wptr_q[PtrW-2:2]) : '0;
  assign sram_wdata_o  = sram_req_o ? wdata_p0 : 32'h0;
  assign sram_wmask_o  = sram_req_o ? wmask_p0 : 4'h0;
  assign fifo_rready_o = pop;
  assign wptr_o        = wptr_q;
  assign depth_o       = depth;
  assign full_o        = phase_diff & (w_off == r_off);

endmodule

// File: tb/tb_spi_fwm_rxf_ctrl.sv
// Directed bench for spi_fwm_rxf_ctrl: byte feeder, SRAM write log and hand-computed checks.
module tb_spi_fwm_rxf_ctrl;

  localparam int SramAw = 9;
  localparam int PtrW   = SramAw + 3;

  logic              clk_i;
  logic              rst_ni;
  logic              fifo_rvalid_i;
  logic              fifo_rready_o;
  logic [7:0]        fifo_rdata_i;
  logic [SramAw-1:0] base_i;
  logic [SramAw-1:0] limit_i;
  logic [7:0]        timer_i;
  logic [PtrW-1:0]   rptr_i;
  logic [PtrW-1:0]   wptr_o;
  logic              full_o;
  logic [PtrW-1:0]   depth_o;
  logic              sram_req_o;
  logic              sram_gnt_i;
  logic [SramAw-1:0] sram_addr_o;
  logic [31:0]       sram_wdata_o;
  logic [3:0]        sram_wmask_o;

  spi_fwm_rxf_ctrl #(.SramAw(SramAw), .PtrW(PtrW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fifo_rvalid_i(fifo_rvalid_i),
    .fifo_rready_o(fifo_rready_o),
    .fifo_rdata_i (fifo_rdata_i),
    .base_i       (base_i),
    .limit_i      (limit_i),
    .timer_i      (timer_i),
    .rptr_i       (rptr_i),
    .wptr_o       (wptr_o),
    .full_o       (full_o),
    .depth_o      (depth_o),
    .sram_req_o   (sram_req_o),
    .sram_gnt_i   (sram_gnt_i),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_wmask_o (sram_wmask_o)
  );

  typedef struct {
    logic [SramAw-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        mask;
    int                cyc;
  } wr_t;

  logic [7:0] feed_q[$];
  int         pop_cyc[$];
  wr_t        wr_log[$];
  int         pop_cnt = 0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte source and SRAM write observer; both sample just before the rising edge.
  initial begin
    fifo_rvalid_i = 1'b0;
    fifo_rdata_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      cyc++;
      fifo_rvalid_i = (feed_q.size() != 0);
      fifo_rdata_i  = (feed_q.size() != 0) ? feed_q[0] : 8'h00;
      #4;
      if (rst_ni && fifo_rvalid_i && fifo_rready_o && feed_q.size() != 0) begin
        void'(feed_q.pop_front());
        pop_cyc.push_back(cyc);
        pop_cnt++;
      end
      if (rst_ni && sram_req_o && sram_gnt_i)
        wr_log.push_back('{sram_addr_o, sram_wdata_o, sram_wmask_o, cyc});
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    feed_q.delete();
    pop_cyc.delete();
    wr_log.delete();
    pop_cnt = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    feed_q.push_back(b);
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && wr_log.size() < n; i++) @(negedge clk_i);
    check_eq({tag, "_nwr"}, wr_log.size(), n);
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int i = 0; i < budget && !sram_req_o; i++) @(negedge clk_i);
    check_eq({tag, "_req"}, {31'd0, sram_req_o}, 32'd1);
  endtask

  initial begin
    int bad;
    int pops0;
    logic [SramAw-1:0] a0;
    logic [31:0]       d0;
    logic [3:0]        m0;

    rst_ni     = 1'b0;
    base_i     = 9'h010;
    limit_i    = 9'h013;
    timer_i    = 8'd0;
    rptr_i     = '0;
    sram_gnt_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_eq("rst_wptr",  wptr_o, 0);
    check_eq("rst_req",   sram_req_o, 0);
    check_eq("rst_full",  full_o, 0);
    check_eq("rst_depth", depth_o, 0);
    check_eq("rst_mask",  sram_wmask_o, 0);
    check_eq("rst_rready", fifo_rready_o, 0);
    rst_ni = 1'b1;

    // Two full words
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_writes("t1", 2, 60);
    if (wr_log.size() >= 2 && pop_cyc.size() >= 8) begin
      check_eq("t1_addr0", wr_log[0].addr, 9'h010);
      check_eq("t1_data0", wr_log[0].data, 32'h04030201);
      check_eq("t1_mask0", wr_log[0].mask, 4'hF);
      check_eq("t1_addr1", wr_log[1].addr, 9'h011);
      check_eq("t1_data1", wr_log[1].data, 32'h08070605);
      check_eq("t1_mask1", wr_log[1].mask, 4'hF);
      check_eq("t1_lat",   wr_log[0].cyc - pop_cyc[3], 1);
    end
    check_eq("t1_wptr",  wptr_o, 8);
    check_eq("t1_depth", depth_o, 8);

    // Idle-timeout partial flush, then resume in the same word
    do_reset();
    timer_i = 8'd4;
    push(8'hAA);
    push(8'hBB);
    wait_writes("t2a", 1, 60);
    if (wr_log.size() >= 1 && pop_cyc.size() >= 2) begin
      check_eq("t2_addr0", wr_log[0].addr, 9'h010);
      check_eq("t2_mask0", wr_log[0].mask, 4'h3);
      check_eq("t2_data0", wr_log[0].data[15:0], 16'hBBAA);
      check_eq("t2_lat",   wr_log[0].cyc - pop_cyc[1], 5);
    end
    check_eq("t2_wptr_a", wptr_o, 2);
    push(8'hCC);
    push(8'hDD);
    wait_writes("t2b", 2, 60);
    if (wr_log.size() >= 2) begin
      check_eq("t2_addr1", wr_log[1].addr, 9'h010);
      check_eq("t2_mask1", wr_log[1].mask, 4'hC);
      check_eq("t2_data1", wr_log[1].data[31:16], 16'hDDCC);
    end
    check_eq("t2_wptr_b", wptr_o, 4);

    // Fill to capacity, then free space and wrap
    do_reset();
    timer_i = 8'd0;
    for (int i = 0; i < 20; i++) push(8'h30 + 8'(i));
    wait_writes("t3a", 4, 120);
    repeat (10) @(negedge clk_i);
    check_eq("t3_nwr_full", wr_log.size(), 4);
    check_eq("t3_pops",   pop_cnt, 16);
    check_eq("t3_full",   full_o, 1);
    check_eq("t3_rready", fifo_rready_o, 0);
    check_eq("t3_depth",  depth_o, 16);
    check_eq("t3_wptr_a", wptr_o, 12'h800);
    if (wr_log.size() >= 4) check_eq("t3_addr3", wr_log[3].addr, 9'h013);
    rptr_i = 12'h004;
    #1;
    check_eq("t3_depth_b", depth_o, 12);
    check_eq("t3_full_b",  full_o, 0);
    wait_writes("t3b", 5, 60);
    if (wr_log.size() >= 5) begin
      check_eq("t3_addr4", wr_log[4].addr, 9'h010);
      check_eq("t3_data4", wr_log[4].data, 32'h43424140);
      check_eq("t3_mask4", wr_log[4].mask, 4'hF);
    end
    check_eq("t3_wptr_b", wptr_o, 12'h804);
    check_eq("t3_full_c", full_o, 1);

    // Grant held off: request fields stable, no pops
    rptr_i = '0;
    do_reset();
    sram_gnt_i = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    wait_req("t4", 30);
    a0 = sram_addr_o;
    d0 = sram_wdata_o;
    m0 = sram_wmask_o;
    check_eq("t4_addr", a0, 9'h010);
    check_eq("t4_data", d0, 32'h14131211);
    check_eq("t4_mask", m0, 4'hF);
    pops0 = pop_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!sram_req_o || sram_addr_o != a0 || sram_wdata_o != d0 ||
          sram_wmask_o != m0 || fifo_rready_o) bad++;
    end
    check_eq("t4_stable", bad, 0);
    check_eq("t4_nopop",  pop_cnt - pops0, 0);
    check_eq("t4_wptr_hold", wptr_o, 0);
    sram_gnt_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("t4_wptr_upd", wptr_o, 4);

    // Reset while a write with three bytes is pending
    do_reset();
    sram_gnt_i = 1'b0;
    timer_i    = 8'd2;
    push(8'h51);
    push(8'h52);
    push(8'h53);
    wait_req("t5", 30);
    check_eq("t5_mask_pre", sram_wmask_o, 4'h7);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("t5_req_rst",  sram_req_o, 0);
    check_eq("t5_wptr_rst", wptr_o, 0);
    check_eq("t5_mask_rst", sram_wmask_o, 0);
    feed_q.delete();
    pop_cyc.delete();
    wr_log.delete();
    pop_cnt = 0;
    repeat (2) @(negedge clk_i);
    rst_ni     = 1'b1;
    sram_gnt_i = 1'b1;
    timer_i    = 8'd0;
    for (int i = 0; i < 4; i++) push(8'h77 + 8'(i));
    wait_writes("t5", 1, 60);
    if (wr_log.size() >= 1) begin
      check_eq("t5_addr", wr_log[0].addr, 9'h010);
      check_eq("t5_data", wr_log[0].data, 32'h7A797877);
      check_eq("t5_mask", wr_log[0].mask, 4'hF);
    end

    // Pop on the expiry cycle restarts the timer
    do_reset();
    timer_i = 8'd3;
    push(8'h61);
    for (int i = 0; i < 30 && pop_cnt < 1; i++) @(negedge clk_i);
    check_eq("t6_pop_a", pop_cnt, 1);
    @(negedge clk_i);
    #2;
    push(8'h62);
    wait_writes("t6", 1, 60);
    repeat (10) @(negedge clk_i);
    check_eq("t6_nwr", wr_log.size(), 1);
    if (wr_log.size() >= 1 && pop_cyc.size() >= 2) begin
      check_eq("t6_gap",  pop_cyc[1] - pop_cyc[0], 3);
      check_eq("t6_lat",  wr_log[0].cyc - pop_cyc[1], 4);
      check_eq("t6_mask", wr_log[0].mask, 4'h3);
      check_eq("t6_data", wr_log[0].data[15:0], 16'h6261);
    end
    check_eq("t6_wptr", wptr_o, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
